regfile_param: RTL

//  Parametrised 2-read/1-write register file for the MIPS core datapath; successor to the fixed 32x32 regfile.

---
 rtl/regfile_param.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with a built-in clear sweep.
// Optional write-first bypass when REGFILE_BYPASS_EN is defined; read-old otherwise.
`timescale 1ns / 1ps

module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] dout1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] dout2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              idle;
  logic              wr_en;
  logic              last;

  assign idle     = (state_q == StIdle);
  assign last     = (ptr_q == {ADDR_W{1'b1}});
  assign clr_busy = ~idle;
  assign clr_done = done_q;

  // Clear request outranks a same-cycle write.
  assign wr_en = idle && wr && !clr_req && !((ZERO_REG != 0) && (waddr == '0));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        if (last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  // Storage has no reset so it can map onto RAM; the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[ptr_q] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= din;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_ok;
  assign byp_ok = idle && wr && !clr_req;
`endif

  always_comb begin
    dout1 = mem[raddr1];
`ifdef REGFILE_BYPASS_EN
    if (byp_ok && (raddr1 == waddr)) dout1 = din;
`endif
    if (!idle || ((ZERO_REG != 0) && (raddr1 == '0))) dout1 = '0;
  end

  always_comb begin
    dout2 = mem[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (byp_ok && (raddr2 == waddr)) dout2 = din;
`endif
    if (!idle || ((ZERO_REG != 0) && (raddr2 == '0))) dout2 = '0;
  end

endmodule
